// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounces mode/inc/dec keys and walks the hour, minute
// and second fields, holding each counter's load line while its preload is edited.
module time_set_ctrl #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic       set_hh,
  output logic       set_mm,
  output logic       set_ss,
  output logic [7:0] s_hh,
  output logic [7:0] s_mm,
  output logic [7:0] s_ss,
  output logic [1:0] edit_sel,
  output logic       blink
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int BCW = $clog2(BLINK_DIV + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEB_CYCLES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] HH_MAX = 8'd23;
  localparam logic [7:0] MS_MAX = 8'd59;

  // Encoding matches edit_sel, so edit_sel is the registered state itself.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EDIT_HH = 2'd1,
    EDIT_MM = 2'd2,
    EDIT_SS = 2'd3
  } state_t;

  state_t state;

  // Key index: 0 = mode, 1 = inc, 2 = dec (all active-low).
  logic [2:0]     key_raw;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     level;
  logic [2:0]     ev;
  logic [DCW-1:0] deb_cnt [3];

  logic [BCW-1:0] blink_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic           ev_mode;
  logic           ev_inc;
  logic           ev_dec;
  logic           any_ev;

  assign key_raw  = {key_dec, key_inc, key_mode};
  assign ev_mode  = ev[0];
  assign ev_inc   = ev[1];
  assign ev_dec   = ev[2];
  assign any_ev   = |ev;
  assign edit_sel = state;

  // A level change is accepted only after DEB_CYCLES consecutive samples
  // disagree with the accepted level; only the high-to-low change is an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      level <= 3'b111;
      ev    <= 3'b000;
      for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int k = 0; k < 3; k++) begin
        ev[k] <= 1'b0;
        if (sync2[k] == level[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          level[k]   <= sync2[k];
          deb_cnt[k] <= '0;
          ev[k]      <= ~sync2[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] max);
    return (v > max) ? 8'd0 : v;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] max,
                                      input logic up);
    if (up) return (v >= max) ? 8'd0 : v + 8'd1;
    return (v == 8'd0) ? max : v - 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      set_hh    <= 1'b0;
      set_mm    <= 1'b0;
      set_ss    <= 1'b0;
      s_hh      <= 8'd0;
      s_mm      <= 8'd0;
      s_ss      <= 8'd0;
      blink     <= 1'b0;
      blink_cnt <= '0;
      tmo_cnt   <= '0;
    end else if (state == RUN) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
      tmo_cnt   <= '0;
      if (ev_mode) begin
        state  <= EDIT_HH;
        set_hh <= 1'b1;
        s_hh   <= clamp(cur_hh, HH_MAX);
        blink  <= 1'b1;
      end
    end else if (ev_mode) begin
      // Mode wins over any inc/dec arriving in the same cycle.
      blink     <= 1'b1;
      blink_cnt <= '0;
      tmo_cnt   <= '0;
      case (state)
        EDIT_HH: begin
          state  <= EDIT_MM;
          set_hh <= 1'b0;
          set_mm <= 1'b1;
          s_mm   <= clamp(cur_mm, MS_MAX);
        end
        EDIT_MM: begin
          state  <= EDIT_SS;
          set_mm <= 1'b0;
          set_ss <= 1'b1;
          s_ss   <= clamp(cur_ss, MS_MAX);
        end
        default: begin
          state  <= RUN;
          set_ss <= 1'b0;
          blink  <= 1'b0;
        end
      endcase
    end else begin
      tmo_cnt <= any_ev ? '0 : tmo_cnt + 1'b1;
      if (!any_ev && tmo_cnt == TMO_LAST) begin
        state     <= RUN;
        set_hh    <= 1'b0;
        set_mm    <= 1'b0;
        set_ss    <= 1'b0;
        blink     <= 1'b0;
        blink_cnt <= '0;
        tmo_cnt   <= '0;
      end else if (ev_inc ^ ev_dec) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
        case (state)
          EDIT_HH: s_hh <= step(s_hh, HH_MAX, ev_inc);
          EDIT_MM: s_mm <= step(s_mm, MS_MAX, ev_inc);
          default: s_ss <= step(s_ss, MS_MAX, ev_inc);
        endcase
      end else if (blink_cnt == BLINK_LAST) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/blink/timeout settings.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_inc = 1'b1;
  logic       key_dec = 1'b1;
  logic [7:0] cur_hh = 8'd22;
  logic [7:0] cur_mm = 8'd0;
  logic [7:0] cur_ss = 8'd37;
  logic       set_hh, set_mm, set_ss;
  logic [7:0] s_hh, s_mm, s_ss;
  logic [1:0] edit_sel;
  logic       blink;

  time_set_ctrl #(
    .DEB_CYCLES (8),
    .BLINK_DIV  (16),
    .TIMEOUT_CYC(200)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_mode(key_mode),
    .key_inc (key_inc),
    .key_dec (key_dec),
    .cur_hh  (cur_hh),
    .cur_mm  (cur_mm),
    .cur_ss  (cur_ss),
    .set_hh  (set_hh),
    .set_mm  (set_mm),
    .set_ss  (set_ss),
    .s_hh    (s_hh),
    .s_mm    (s_mm),
    .s_ss    (s_ss),
    .edit_sel(edit_sel),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   n_checks = 0;
  int   n_errors = 0;
  int   chg_lat;
  int   chg_cyc;
  logic chg_blink;
  logic found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold the selected keys low for 14 cycles, then high for 14 cycles.
  // Records the cycle (relative to the press) at which edit_sel changed.
  task automatic press(input logic m, input logic i, input logic d);
    logic [1:0] sel0;
    sel0    = edit_sel;
    chg_lat = 0;
    key_mode = ~m;
    key_inc  = ~i;
    key_dec  = ~d;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (chg_lat == 0 && edit_sel != sel0) begin
        chg_lat   = n;
        chg_cyc   = cyc;
        chg_blink = blink;
      end
    end
    key_mode = 1'b1;
    key_inc  = 1'b1;
    key_dec  = 1'b1;
    repeat (14) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_edit_sel", edit_sel, 0);
    chk("rst_set", {set_hh, set_mm, set_ss}, 3'b000);
    chk("rst_s", {s_hh, s_mm, s_ss}, 24'h0);
    chk("rst_blink", blink, 0);
    #10 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // RUN -> EDIT_HH with cur_hh=22
    press(1, 0, 0);
    chk("hh_entry_lat", (chg_lat >= 1 && chg_lat <= 12), 1);
    chk("hh_entry_blink", chg_blink, 1);
    chk("hh_edit_sel", edit_sel, 1);
    chk("hh_set", {set_hh, set_mm, set_ss}, 3'b100);
    chk("hh_preload", s_hh, 22);
    chk("hh_blink_toggled", blink, 0);

    press(0, 1, 0);
    chk("hh_inc_23", s_hh, 23);
    chk("hh_inc_blink_restart", blink, 0);
    press(0, 1, 0);
    chk("hh_inc_wrap", s_hh, 0);
    chk("hh_set_held", set_hh, 1);

    // EDIT_MM with cur_mm=0, dec wraps to 59
    press(1, 0, 0);
    chk("mm_edit_sel", edit_sel, 2);
    chk("mm_set", {set_hh, set_mm, set_ss}, 3'b010);
    chk("mm_preload", s_mm, 0);
    chk("mm_hh_kept", s_hh, 0);
    press(0, 0, 1);
    chk("mm_dec_wrap", s_mm, 59);

    // EDIT_SS
    press(1, 0, 0);
    chk("ss_edit_sel", edit_sel, 3);
    chk("ss_set", {set_hh, set_mm, set_ss}, 3'b001);
    chk("ss_preload", s_ss, 37);

    // Short glitches on all keys produce no event
    repeat (10) begin
      key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      key_mode = 1'b1; key_inc = 1'b1; key_dec = 1'b1;
      repeat (5) @(posedge clk);
      #1;
    end
    chk("glitch_edit_sel", edit_sel, 3);
    chk("glitch_s", {s_hh, s_mm, s_ss}, {8'd0, 8'd59, 8'd37});

    // Idle timeout back to RUN, 200 cycles after entering EDIT_SS
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (edit_sel == 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    chk("tmo_seen", found, 1);
    chk("tmo_cycles", cyc - chg_cyc, 200);
    chk("tmo_set", {set_hh, set_mm, set_ss}, 3'b000);
    chk("tmo_blink", blink, 0);
    chk("tmo_ss_kept", s_ss, 37);

    // mode + inc together in EDIT_HH: mode wins, s_hh unchanged
    cur_hh = 8'd5;
    cur_mm = 8'd59;
    press(1, 0, 0);
    chk("hh2_preload", s_hh, 5);
    press(1, 1, 0);
    chk("modeinc_edit_sel", edit_sel, 2);
    chk("modeinc_hh_kept", s_hh, 5);
    chk("modeinc_mm_preload", s_mm, 59);

    // inc + dec together: ignored; then inc wraps 59 -> 0
    press(0, 1, 1);
    chk("incdec_ignored", s_mm, 59);
    press(0, 1, 0);
    chk("mm_inc_wrap", s_mm, 0);

    // Out-of-range preload clamps to 0; dec from 0 wraps to 59
    cur_ss = 8'd70;
    press(1, 0, 0);
    chk("ss_clamp_sel", edit_sel, 3);
    chk("ss_clamp", s_ss, 0);
    press(0, 0, 1);
    chk("ss_dec_wrap", s_ss, 59);

    // EDIT_SS --mode--> RUN
    press(1, 0, 0);
    chk("run_edit_sel", edit_sel, 0);
    chk("run_set", {set_hh, set_mm, set_ss}, 3'b000);
    chk("run_blink", blink, 0);
    chk("run_s_kept", {s_hh, s_mm, s_ss}, {8'd5, 8'd0, 8'd59});

    // inc in RUN is ignored
    press(0, 1, 0);
    chk("run_inc_ignored", {s_hh, s_mm, s_ss}, {8'd5, 8'd0, 8'd59});
    chk("run_inc_sel", edit_sel, 0);

    // Reset asserted mid-edit in EDIT_MM
    cur_hh = 8'd10;
    cur_mm = 8'd20;
    press(1, 0, 0);
    press(1, 0, 0);
    chk("pre_rst_sel", edit_sel, 2);
    chk("pre_rst_s", {s_hh, s_mm}, {8'd10, 8'd20});
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_set", {set_hh, set_mm, set_ss}, 3'b000);
    chk("midrst_s", {s_hh, s_mm, s_ss}, 24'h0);
    chk("midrst_edit_sel", edit_sel, 0);
    chk("midrst_blink", blink, 0);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_sel", edit_sel, 0);
    press(1, 0, 0);
    chk("postrst_entry_sel", edit_sel, 1);
    chk("postrst_preload", s_hh, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
